// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU opcode sequencer.
// Contents:
//   OPW          opcode width (opcode space is NUM_OPS = 2**OPW)
//   NUM_OPS      number of distinct opcodes
//   seq_state_e  sequencer FSM encoding (IDLE/RUN/STALL/FIN)
//   seq_rec_t    {opcode, x, y} result record at the default 8-bit data width
package alu_seq_pkg;

    localparam int OPW       = 4;
    localparam int NUM_OPS   = 2 ** OPW;
    localparam int REC_DW    = 8;

    // IDLE is all-zero so a reset sequencer reports state 0 on its debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [OPW-1:0]    opcode;
        logic [REC_DW-1:0] x;
        logic [REC_DW-1:0] y;
    } seq_rec_t;

endpackage

// File: rtl/seq_result_fifo.sv
// Synchronous result FIFO, DEPTH entries of DW bits.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (empties FIFO)
//   push       write wdata; accepted when not full, or when a pop happens
//              on the same edge (full pass-through)
//   pop        remove the head entry; ignored when empty
//   wdata      entry to write
//   rdata      head entry (meaningful only when empty = 0)
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored entries, 0..DEPTH
module seq_result_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Self-driving opcode sweeper for the 8-bit ALU.
// On start it latches operands and an inclusive (wrapping) opcode range,
// drives each opcode into the ALU, samples x/y ALU_LAT edges after each
// opcode load and queues {opcode, x, y} records for a downstream consumer.
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   start, a_in, b_in             sweep request and operands (sampled in IDLE only)
//   op_first, op_last             inclusive opcode range, may wrap 15 -> 0
//   alu_a, alu_b, alu_opcode      drive the ALU
//   alu_x, alu_y                  ALU results
//   res_valid, res_ready          result stream handshake
//   res_opcode, res_x, res_y      head record
//   busy                          sweep in progress (RUN or STALL)
//   done                          one-cycle pulse after the final record is pushed
//   dbg_state, dbg_count          FSM state and FIFO occupancy for observation
//
// Result stream handshake: a record transfers on every rising edge where
// res_valid & res_ready are both 1. While res_valid = 1 the res_* fields hold
// the head record and stay stable until it transfers; res_valid never drops
// without a transfer except on reset.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a_in,
    input  logic [WIDTH-1:0]       b_in,
    input  logic [OPW-1:0]         op_first,
    input  logic [OPW-1:0]         op_last,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [OPW-1:0]         alu_opcode,
    input  logic [WIDTH-1:0]       alu_x,
    input  logic [WIDTH-1:0]       alu_y,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [OPW-1:0]         res_opcode,
    output logic [WIDTH-1:0]       res_x,
    output logic [WIDTH-1:0]       res_y,
    output logic                   busy,
    output logic                   done,
    output seq_state_e             dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int REC_W = OPW + 2 * WIDTH;
    localparam int CW    = 3;   // holds 0..ALU_LAT-1 for ALU_LAT up to 7

    seq_state_e       state, state_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [OPW-1:0]   op_q, op_nxt;
    logic [OPW:0]     rem_q, rem_nxt;    // 1..16 operations left, needs OPW+1 bits
    logic [CW-1:0]    wait_q, wait_nxt;

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] head;

    assign pop = !fifo_empty && res_ready;

    // RUN pushes on the ALU_LAT-th edge after an opcode load; STALL retries
    // every cycle because the ALU outputs are already settled.
    assign push_req = ((state == ST_RUN) && (wait_q == CW'(ALU_LAT - 1)))
                    || (state == ST_STALL);
    assign push_ok  = push_req && (!fifo_full || pop);

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        rem_nxt   = rem_q;
        wait_nxt  = wait_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_nxt     = a_in;
                    b_nxt     = b_in;
                    op_nxt    = op_first;
                    // Modulo-16 distance plus one: equal bounds give one op,
                    // op_last < op_first wraps through 15 -> 0.
                    rem_nxt   = {1'b0, OPW'(op_last - op_first)} + (OPW+1)'(1);
                    wait_nxt  = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (push_ok) begin
                    rem_nxt  = rem_q - (OPW+1)'(1);
                    wait_nxt = '0;
                    if (rem_q == (OPW+1)'(1)) begin
                        state_nxt = ST_FIN;
                    end else begin
                        op_nxt    = op_q + OPW'(1);
                        state_nxt = ST_RUN;
                    end
                end else if (push_req) begin
                    state_nxt = ST_STALL;
                end else begin
                    wait_nxt = wait_q + CW'(1);
                end
            end
            ST_FIN: begin
                // start is deliberately not looked at here.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            rem_q  <= '0;
            wait_q <= '0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            op_q   <= op_nxt;
            rem_q  <= rem_nxt;
            wait_q <= wait_nxt;
        end
    end

    seq_result_fifo #(
        .DW    (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .wdata ({op_q, alu_x, alu_y}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_count)
    );

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign busy       = (state == ST_RUN) || (state == ST_STALL);
    assign done       = (state == ST_FIN);
    assign dbg_state  = state;

    // Unwritten FIFO storage is never exposed: fields read 0 when empty.
    assign res_valid  = !fifo_empty;
    assign res_opcode = fifo_empty ? '0 : head[REC_W-1 -: OPW];
    assign res_x      = fifo_empty ? '0 : head[2*WIDTH-1 -: WIDTH];
    assign res_y      = fifo_empty ? '0 : head[WIDTH-1:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W     = 8;
  localparam int RW    = OPW + 2 * W;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with combinational ALU (ALU_LAT = 1) ----------------
  logic            start, res_ready, res_valid, busy, done;
  logic [W-1:0]    a_in, b_in, alu_a, alu_b, alu_x, alu_y, res_x, res_y;
  logic [OPW-1:0]  op_first, op_last, alu_opcode, res_opcode;
  seq_state_e      dbg_state;
  logic [CNTW-1:0] dbg_count;

  // ---------------- DUT with pipelined ALU (ALU_LAT = 3) ----------------
  logic            l3_start, l3_res_ready, l3_res_valid, l3_busy, l3_done;
  logic [W-1:0]    l3_a_in, l3_b_in, l3_alu_a, l3_alu_b, l3_alu_x, l3_alu_y, l3_res_x, l3_res_y;
  logic [OPW-1:0]  l3_op_first, l3_op_last, l3_alu_opcode, l3_res_opcode;
  seq_state_e      l3_dbg_state;
  logic [CNTW-1:0] l3_dbg_count;

  // ALU model: arbitrary but opcode-dependent function of a and b.
  function automatic logic [2*W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    x = a + (b ^ W'(op));
    y = a ^ b ^ {op, op};
    return {x, y};
  endfunction

  assign {alu_x, alu_y} = alu_fn(alu_opcode, alu_a, alu_b);

  // Two pipeline registers behind the function: result valid ALU_LAT-1 edges
  // after the opcode changes, and first sampled on the ALU_LAT-th edge.
  logic [2*W-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= alu_fn(l3_alu_opcode, l3_alu_a, l3_alu_b);
    p2 <= p1;
  end
  assign {l3_alu_x, l3_alu_y} = p2;

  alu_op_sequencer #(.WIDTH(W), .ALU_LAT(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .op_first(op_first), .op_last(op_last),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_x(alu_x), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_opcode(res_opcode), .res_x(res_x), .res_y(res_y),
    .busy(busy), .done(done), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  alu_op_sequencer #(.WIDTH(W), .ALU_LAT(3), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .start(l3_start), .a_in(l3_a_in), .b_in(l3_b_in),
    .op_first(l3_op_first), .op_last(l3_op_last),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_opcode(l3_alu_opcode),
    .alu_x(l3_alu_x), .alu_y(l3_alu_y),
    .res_valid(l3_res_valid), .res_ready(l3_res_ready),
    .res_opcode(l3_res_opcode), .res_x(l3_res_x), .res_y(l3_res_y),
    .busy(l3_busy), .done(l3_done), .dbg_state(l3_dbg_state), .dbg_count(l3_dbg_count)
  );

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp3_q[$];
  logic [W-1:0]  mdl_a = '0, mdl_b = '0;
  int n_pass = 0, n_total = 0;
  int done_seen = 0, busy_cycles = 0;
  int unsigned start_cyc = 0;
  bit rdy_random = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected records of one sweep: every opcode from f up to l inclusive,
  // walking modulo 16.
  task automatic model_sweep(input logic [W-1:0] a, input logic [W-1:0] b, input int f, input int l, input bit lat3);
    int n;
    int op;
    logic [RW-1:0] rec;
    n = ((l - f + NUM_OPS) % NUM_OPS) + 1;
    for (int i = 0; i < n; i++) begin
      op  = (f + i) % NUM_OPS;
      rec = {OPW'(op), alu_fn(OPW'(op), a, b)};
      if (lat3) exp3_q.push_back(rec);
      else exp_q.push_back(rec);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_sweep(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] f, input logic [OPW-1:0] l);
    start = 1'b1; a_in = a; b_in = b; op_first = f; op_last = l;
    model_sweep(a, b, int'(f), int'(l), 1'b0);
    tick;
    start_cyc = cyc;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);
    op_first = OPW'($urandom); op_last = OPW'($urandom);
    mdl_a = a; mdl_b = b;
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      tick;
      n++;
    end
    if (!done) chk("done_timeout", 32'(done), 1);
    lat = int'(cyc - start_cyc);
  endtask

  task automatic drain;
    int n;
    res_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick;
      n++;
    end
    chk("drain_all_records", exp_q.size(), 0);
    tick;
    chk("drain_res_valid_low", 32'(res_valid), 0);
  endtask

  // random ready for the random phase
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_random) res_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (res_valid) begin
        if (exp_q.size() == 0) chk("res_valid_unexpected", 32'(res_valid), 0);
        else begin
          chk("res_record", {res_opcode, res_x, res_y}, exp_q[0]);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      chk("alu_a", alu_a, mdl_a);
      chk("alu_b", alu_b, mdl_b);
      if (busy) busy_cycles++;
      if (done) begin
        done_seen++;
        chk("done_not_busy", 32'(busy), 0);
      end
      if (l3_res_valid) begin
        if (exp3_q.size() == 0) chk("l3_res_valid_unexpected", 32'(l3_res_valid), 0);
        else begin
          chk("l3_res_record", {l3_res_opcode, l3_res_x, l3_res_y}, exp3_q[0]);
          if (l3_res_ready) void'(exp3_q.pop_front());
        end
      end
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    start = 0; a_in = 0; b_in = 0; op_first = 0; op_last = 0; res_ready = 0;
    l3_start = 0; l3_a_in = 0; l3_b_in = 0; l3_op_first = 0; l3_op_last = 0; l3_res_ready = 0;
    repeat (3) tick;

    // reset state
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // hand-computed model pins
    chk("model_pin_op0", alu_fn(4'd0, 8'h55, 8'hC3), 32'h1896);
    chk("model_pin_op15", alu_fn(4'd15, 8'h55, 8'hC3), 32'h2169);
    chk("model_pin_op7", alu_fn(4'd7, 8'h12, 8'h34), 32'h4551);

    // full sweep, no backpressure
    res_ready = 1'b1; busy_cycles = 0; done_seen = 0;
    start_sweep(8'h55, 8'hC3, 4'd0, 4'd15);
    chk("full_first_opcode", alu_opcode, 0);
    chk("full_busy_after_start", 32'(busy), 1);
    wait_done(200, lat);
    chk("full_done_latency", lat, 16);
    // start during the FIN cycle must be ignored
    start = 1'b1; op_first = 4'd3; op_last = 4'd3;
    tick;
    start = 1'b0;
    chk("fin_start_ignored_busy", 32'(busy), 0);
    chk("fin_start_ignored_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("full_done_one_cycle", 32'(done), 0);
    chk("full_busy_cycles", busy_cycles, 16);
    chk("full_done_count", done_seen, 1);
    drain;

    // wrap-around range 14 -> 1
    start_sweep(8'h21, 8'h9A, 4'd14, 4'd1);
    chk("wrap_first_opcode", alu_opcode, 14);
    wait_done(200, lat);
    chk("wrap_done_latency", lat, 4);
    drain;

    // single operation
    start_sweep(8'h12, 8'h34, 4'd7, 4'd7);
    tick;
    chk("single_head_literal", {res_opcode, res_x, res_y}, 32'h74551);
    chk("single_done", 32'(done), 1);
    drain;

    // backpressure: consumer stalled on a full sweep
    res_ready = 1'b0; done_seen = 0;
    start_sweep(8'h55, 8'hC3, 4'd0, 4'd15);
    repeat (5) tick;
    chk("bp_state_stall", 32'(dbg_state), 32'(ST_STALL));
    chk("bp_opcode_held", alu_opcode, 4);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_fifo_full", dbg_count, 4);
    repeat (3) tick;
    chk("bp_opcode_still_held", alu_opcode, 4);
    chk("bp_no_done", done_seen, 0);
    res_ready = 1'b1;
    wait_done(200, lat);
    drain;
    chk("bp_done_once", done_seen, 1);

    // pass-through when full: one-cycle ready at the sampling edge
    res_ready = 1'b0;
    start_sweep(8'h0F, 8'hF0, 4'd0, 4'd7);
    repeat (4) tick;
    chk("pt_full_before", dbg_count, 4);
    chk("pt_opcode_before", alu_opcode, 4);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("pt_count_kept", dbg_count, 4);
    chk("pt_no_stall", 32'(dbg_state), 32'(ST_RUN));
    chk("pt_opcode_advanced", alu_opcode, 5);
    res_ready = 1'b1;
    wait_done(200, lat);
    drain;

    // start during RUN is ignored
    start_sweep(8'h33, 8'h44, 4'd2, 4'd5);
    tick; tick;
    start = 1'b1; a_in = 8'hEE; op_first = 4'd9; op_last = 4'd9;
    tick;
    start = 1'b0;
    wait_done(200, lat);
    chk("ign_done_latency", lat, 4);
    drain;

    // reset mid-sweep
    done_seen = 0;
    start_sweep(8'h55, 8'hC3, 4'd0, 4'd15);
    repeat (5) tick;
    rst = 1'b1;
    tick;
    exp_q.delete();
    mdl_a = '0; mdl_b = '0;
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_opcode", alu_opcode, 0);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    chk("mid_rst_res_fields", {res_opcode, res_x, res_y}, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (20) tick;
    chk("mid_rst_no_done", done_seen, 0);
    chk("mid_rst_still_empty", 32'(res_valid), 0);

    // ALU_LAT = 3 with pipelined ALU
    l3_res_ready = 1'b1;
    l3_start = 1'b1; l3_a_in = 8'h12; l3_b_in = 8'h34; l3_op_first = 4'd0; l3_op_last = 4'd3;
    model_sweep(8'h12, 8'h34, 0, 3, 1'b1);
    tick;
    start_cyc = cyc;
    l3_start = 1'b0;
    chk("l3_alu_a", l3_alu_a, 32'h12);
    repeat (2) tick;
    chk("l3_no_record_before_lat", 32'(l3_res_valid), 0);
    tick;
    chk("l3_first_record_at_lat", 32'(l3_res_valid), 1);
    begin
      int n;
      n = 0;
      while (!l3_done && n < 100) begin
        tick;
        n++;
      end
    end
    chk("l3_done_latency", int'(cyc - start_cyc), 12);
    repeat (3) tick;
    chk("l3_all_records", exp3_q.size(), 0);

    // randomized sweeps with random backpressure
    for (int s = 0; s < 6; s++) begin
      logic [W-1:0] ra, rb;
      logic [OPW-1:0] rf, rl;
      ra = W'($urandom); rb = W'($urandom);
      rf = OPW'($urandom_range(0, 15)); rl = OPW'($urandom_range(0, 15));
      done_seen = 0;
      rdy_random = 1'b1;
      start_sweep(ra, rb, rf, rl);
      wait_done(600, lat);
      rdy_random = 1'b0;
      drain;
      chk("rand_done_once", done_seen, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator for the 8-bit ALU: drives operands and walks a programmable opcode range into the ALU.
- Samples the ALU x/y outputs for each opcode and queues {opcode, x, y} result records.
- Drains records through a valid/ready stream.
- Sits between the control/debug logic and the ALU. Replaces the open-loop opcode sweep with a synthesizable self-driving sweeper.

Parameters:
- WIDTH, 8, operand/result width (a, b, x, y).
- OPW, 4, opcode width; the opcode space is 2**OPW = 16.
- ALU_LAT, 1, cycles from an opcode change to valid x/y. Range 1..7; 1 = combinational ALU.
- DEPTH, 4, result FIFO depth in records. Power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; sampled only in IDLE.
- a_in  in  WIDTH  operand a, latched at start.
- b_in  in  WIDTH  operand b, latched at start.
- op_first  in  OPW  first opcode, latched at start.
- op_last  in  OPW  last opcode (inclusive), latched at start.
- alu_a  out  WIDTH  operand a to the ALU.
- alu_b  out  WIDTH  operand b to the ALU.
- alu_opcode  out  OPW  opcode to the ALU.
- alu_x  in  WIDTH  ALU result x.
- alu_y  in  WIDTH  ALU result y.
- res_valid  out  1  a result record is available.
- res_ready  in  1  consumer accepts the record.
- res_opcode  out  OPW  opcode of the head record.
- res_x  out  WIDTH  x of the head record.
- res_y  out  WIDTH  y of the head record.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse: the last record of the sweep has been pushed.

Behaviour:
- Reset:
  - all outputs are 0; state IDLE; FIFO emptied; wait counter 0.
  - Reset mid-sweep aborts the sweep. Queued records are discarded and no done pulse is produced.
- States: IDLE, RUN, STALL, FIN.
- IDLE:
  - When start=1, latch a_in, b_in, op_first and op_last.
  - Load alu_opcode=op_first, set busy=1, go to RUN.
  - remaining = ((op_last - op_first) mod 16) + 1, range 1..16.
  - op_last < op_first wraps through 15 to 0. op_first == op_last gives exactly one operation.
- start while not in IDLE is ignored; it is not queued.
- alu_a and alu_b hold the latched operands from the start edge until the next start. They are not cleared at FIN.
- RUN:
  - The wait counter counts ALU_LAT edges after each opcode load.
  - At the ALU_LAT-th edge, sample alu_x/alu_y and push {alu_opcode, alu_x, alu_y}.
  - On the same edge, decrement remaining and load alu_opcode+1 (mod 16) if remaining is still non-zero.
  - Operations run back-to-back; throughput is one op per ALU_LAT cycles.
- Push permission: the push is allowed if count < DEPTH, or if a pop (res_valid & res_ready) occurs on the same edge (full pass-through).
- STALL:
  - Entered when a push is denied. alu_opcode is held and the push is retried every cycle with no re-wait, since x/y are stable.
  - Return to RUN on the first successful push.
- FIN:
  - Entered on the edge that pushes the final record. In FIN, done=1 and busy=0 for one cycle, then go to IDLE.
  - start in the FIN cycle is ignored.
- FIFO:
  - FIFO order matches opcode issue order.
  - res_* show the head record whenever res_valid=1. They are stable while res_valid=1 and res_ready=0.
  - Pop on res_valid & res_ready. Draining continues in IDLE after done.
- Width rules:
  - Opcode arithmetic is OPW-bit modulo.
  - remaining is OPW+1 bits wide so that 16 fits.
  - x/y are captured unmodified.

Decomposition:
- Package alu_seq_pkg:
  - OPW;
  - NUM_OPS=16;
  - the state encoding (IDLE/RUN/STALL/FIN);
  - the result record struct {opcode, x, y}.
- Sub-module seq_result_fifo:
  - synchronous DEPTH x (OPW+2*WIDTH) FIFO;
  - ports: push, pop, full, empty, count;
  - supports same-cycle push and pop when full.

Test Plan:
- Full sweep: a=0x55, b=0xC3, op_first=0, op_last=15, res_ready=1, ALU_LAT=1.
  - Expect 16 records with opcodes 0..15 in order, x/y matching the ALU model.
  - done pulses exactly 16 cycles after the start edge; busy is high for 16 cycles.
- Wrap and single op:
  - op_first=14, op_last=1 -> records with opcodes 14, 15, 0, 1, then done.
  - op_first=op_last=7 -> exactly one record with opcode 7.
- Backpressure: res_ready=0 with DEPTH=4 on a full sweep.
  - After 4 pushes: STALL, alu_opcode held at 4, busy=1, no done.
  - Raise res_ready -> the sweep completes with 16 records total and no loss or duplication.
- Pass-through when full: FIFO full, res_ready pulsed for one cycle at the sampling edge.
  - The pop and push both occur on that edge; count stays at 4; no STALL entry.
- Reset and ignored start:
  - Assert rst after 5 records -> outputs 0 next cycle, res_valid=0, no done.
  - start pulsed during RUN -> no effect on the range or on remaining.
- ALU_LAT=3 with a pipelined ALU model, sweep 0..3:
  - Each record is sampled 3 edges after its opcode load.
  - done 12 cycles after the start edge.
